// File: rtl/ifu_pkg.sv
// Shared IFU definitions: widths, reset PC, FSM encoding and the `Vec width macro.
// Compile this file first; the `Vec macro is used by every other IFU file.
`ifndef IFU_PKG_SV
`define IFU_PKG_SV

`define Vec(w) logic [(w)-1:0]

package ifu_pkg;

    localparam int PcWidth   = 64;
    localparam int InstWidth = 32;

    localparam logic [PcWidth-1:0] ResetPcDefault = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

`endif

// File: rtl/ifu_pc_reg.sv
// Program-counter register for the IFU.
// Synchronous active-high reset to RESET_VAL, plus a write enable.
module pc_reg
    import ifu_pkg::*;
#(
    parameter logic [PcWidth-1:0] RESET_VAL = ResetPcDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  `Vec(PcWidth)      d,
    output `Vec(PcWidth)      q
);

    `Vec(PcWidth) pc_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else if (we) begin
            pc_q <= d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request, response capture, redirect handling.
// Optional IFU_MISALIGN_CHECK_EN: align redirect targets and pulse misalign_err.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [PcWidth-1:0] RESET_PC = ResetPcDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [PcWidth-1:0]   imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [InstWidth-1:0] imem_rsp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [InstWidth-1:0] out_inst,
    output logic [PcWidth-1:0]   out_pc,
    input  logic                 redirect_valid,
    input  logic [PcWidth-1:0]   redirect_pc,
    output logic                 misalign_err
);

    state_e           state_q, state_d;
    `Vec(PcWidth)     pc_q, pc_d, redirect_tgt;
    logic             pc_we;
    `Vec(InstWidth)   out_inst_q, out_inst_d;
    `Vec(PcWidth)     out_pc_q, out_pc_d;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redirect_tgt = {redirect_pc[PcWidth-1:2], 2'b00};

    always_comb begin
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misalign_err = misalign_q;
`else
    assign redirect_tgt = redirect_pc;
    assign misalign_err = 1'b0;
`endif

    pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .we  (pc_we),
        .d   (pc_d),
        .q   (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            out_inst_q <= '0;
            out_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
        end
    end

    // NOTE: each combinational block assigns defaults first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ:  if (imem_req_ready) state_d = redirect_valid ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (redirect_valid)      state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                else if (imem_rsp_valid) state_d = ST_HOLD;
            end
            ST_DROP: if (imem_rsp_valid) state_d = ST_REQ;
            ST_HOLD: if (redirect_valid || out_ready) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase
    end

    // Redirect wins over the sequential pc+4 advance in every state.
    always_comb begin
        pc_we      = 1'b0;
        pc_d       = pc_q;
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        if (redirect_valid) begin
            pc_we = 1'b1;
            pc_d  = redirect_tgt;
        end else if (state_q == ST_HOLD && out_ready) begin
            pc_we = 1'b1;
            pc_d  = pc_q + 64'd4;
        end
        if (state_q == ST_WAIT && imem_rsp_valid && !redirect_valid) begin
            out_inst_d = imem_rsp_data;
            out_pc_d   = pc_q;
        end
    end

    always_comb begin
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        case (state_q)
            ST_REQ:  imem_req_valid = 1'b1;
            ST_HOLD: out_valid      = 1'b1;
            default: ;
        endcase
    end

    assign imem_req_addr = pc_q;
    assign out_inst      = out_inst_q;
    assign out_pc        = out_pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; expectations adapt to IFU_MISALIGN_CHECK_EN.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        misalign_err;

    int vectors    = 0;
    int miscompares = 0;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ with ready=1: accept, respond one cycle later, land in HOLD.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] data);
        check("req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("req_addr", imem_req_addr, addr);
        step();
        check("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        check("wait_no_out", {63'd0, out_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_inst", {32'd0, out_inst}, {32'd0, data});
        check("hold_pc", out_pc, addr);
    endtask

    initial begin
        logic [63:0] exp_addr;
        logic        exp_mis;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        step();
        step();

        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_inst", {32'd0, out_inst}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
        rst = 1'b0;

        // Streaming with the decoder always ready.
        fetch(64'h8000_0000, 32'h0000_0013);
        step();
        fetch(64'h8000_0004, 32'h0010_0093);
        step();

        // Backpressure in HOLD.
        out_ready = 1'b0;
        fetch(64'h8000_0008, 32'h0010_0073);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_inst", {32'd0, out_inst}, 64'h0010_0073);
            check("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_addr", imem_req_addr, 64'h8000_000C);
        check("bp_release_req", {63'd0, imem_req_valid}, 64'd1);

        // Redirect while waiting; late response must be dropped.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        check("drop_no_req", {63'd0, imem_req_valid}, 64'd0);
        step();
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        check("drop_no_out", {63'd0, out_valid}, 64'd0);
        step();
        imem_rsp_valid = 1'b0;
        check("drop_exit_out", {63'd0, out_valid}, 64'd0);
        check("drop_exit_req", {63'd0, imem_req_valid}, 64'd1);
        check("drop_exit_addr", imem_req_addr, 64'h8000_0100);

        // Redirect in HOLD with a simultaneous handshake.
        fetch(64'h8000_0100, 32'h1111_1111);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0040;
        step();
        redirect_valid = 1'b0;
        check("hold_redir_out", {63'd0, out_valid}, 64'd0);
        check("hold_redir_addr", imem_req_addr, 64'h8000_0040);

        // Redirect to a misaligned target while REQ is stalled.
`ifdef IFU_MISALIGN_CHECK_EN
        exp_addr = 64'h8000_0040;
        exp_mis  = 1'b1;
`else
        exp_addr = 64'h8000_0042;
        exp_mis  = 1'b0;
`endif
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0042;
        step();
        redirect_valid = 1'b0;
        check("mis_req_addr", imem_req_addr, exp_addr);
        check("mis_pulse", {63'd0, misalign_err}, {63'd0, exp_mis});
        step();
        check("mis_pulse_end", {63'd0, misalign_err}, 64'd0);
        check("mis_still_req", {63'd0, imem_req_valid}, 64'd1);
        imem_req_ready = 1'b1;

        // Redirect in WAIT coinciding with the response.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        check("wait_rsp_redir_out", {63'd0, out_valid}, 64'd0);
        check("wait_rsp_redir_addr", imem_req_addr, 64'h8000_0200);

        // pc+4 wraps modulo 2^64.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0001);
        step();
        check("wrap_addr", imem_req_addr, 64'h0);

        // Reset while WAIT; stale response one cycle after reset falls.
        step();
        check("pre_rst_wait", {63'd0, imem_req_valid}, 64'd0);
        rst = 1'b1;
        step();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        check("post_rst_addr", imem_req_addr, 64'h8000_0000);
        check("post_rst_out_pc", out_pc, 64'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        step();
        imem_rsp_valid = 1'b0;
        check("stale_out_valid", {63'd0, out_valid}, 64'd0);
        check("stale_req_valid", {63'd0, imem_req_valid}, 64'd1);
        imem_req_ready = 1'b1;
        fetch(64'h8000_0000, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the PC loaded at reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_req_addr  output  64  fetch address, equal to the current PC.
REQ-007 imem_rsp_valid  input  1  instruction word valid.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 out_valid  output  1  instruction available to the decoder.
REQ-010 out_ready  input  1  decoder accepts the instruction.
REQ-011 out_inst  output  32  instruction presented to the decoder.
REQ-012 out_pc  output  64  PC of out_inst.
REQ-013 redirect_valid  input  1  execute stage requests a jump (jal/jalr).
REQ-014 redirect_pc  input  64  jump target.
REQ-015 misalign_err  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-016 The FSM SHALL have exactly four states: REQ, WAIT, DROP, HOLD; at most one memory request SHALL be outstanding.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; imem_req_ready=1 moves to WAIT; otherwise stay in REQ.
REQ-018 WAIT: imem_req_valid=0; imem_rsp_valid=1 captures imem_rsp_data into out_inst and pc into out_pc, then moves to HOLD.
REQ-019 HOLD: out_valid=1; out_inst/out_pc SHALL stay stable until the handshake; out_valid&out_ready sets pc<=pc+4 (64-bit, wraps modulo 2^64) and moves to REQ.
REQ-020 out_valid SHALL be 1 only in HOLD; imem_req_valid SHALL be 1 only in REQ.
REQ-021 imem_rsp_valid SHALL be ignored in REQ and HOLD; minimum fetch-to-out_valid latency is 2 cycles after request acceptance (accept edge, response edge).
REQ-022 redirect_valid SHALL load pc<=redirect_pc in every state and SHALL take priority over pc+4.
REQ-023 Redirect in REQ without imem_req_ready: stay in REQ; the next cycle issues the new pc.
REQ-024 Redirect in REQ with imem_req_ready: go to DROP, because the request just accepted carries the stale address.
REQ-025 Redirect in WAIT: go to DROP; if imem_rsp_valid is also 1 that cycle, discard that response and go to REQ.
REQ-026 DROP: imem_req_valid=0, out_valid=0; imem_rsp_valid=1 discards the data and goes to REQ.
REQ-027 Redirect in HOLD: go to REQ and deassert out_valid next cycle.
REQ-028 In REQ-027, if out_ready=1 in the same cycle, the handshake SHALL count as completed; pc still takes redirect_pc.

Reset
REQ-029 rst=1 SHALL force: state=REQ, pc=RESET_PC, out_inst=32'h0, out_pc=64'h0, misalign_err=0.
REQ-030 Reset mid-fetch (WAIT or DROP) SHALL abandon the outstanding request, so a response arriving after reset falls in REQ and is ignored.
REQ-031 The first request after rst falls SHALL present RESET_PC in that same cycle.

Configuration
REQ-032 Macro IFU_MISALIGN_CHECK_EN defined:
  - a redirect with redirect_pc[1:0]!=0 SHALL load {redirect_pc[63:2],2'b00};
  - misalign_err SHALL pulse 1 for exactly one cycle, the cycle after the redirect.
REQ-033 Macro IFU_MISALIGN_CHECK_EN undefined:
  - redirect_pc SHALL be loaded unmodified;
  - misalign_err SHALL be tied to 0 (the port remains present).

Structure
REQ-034 PcWidth (64), InstWidth (32), the RESET_PC default and the FSM state encodings SHALL live in the shared defines include; `Vec SHALL be used for widths.
REQ-035 One sub-module, pc_reg (synchronous-reset register with reset value and write enable), SHALL hold pc; the FSM and output capture SHALL be in ifu.

Verification
REQ-036 Reset, then memory always ready and responding 1 cycle after acceptance, out_ready=1:
  - first address is 0x8000_0000;
  - out_pc sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008;
  - out_inst equals the data returned.
REQ-037 Backpressure: out_ready=0 for 5 cycles while in HOLD with inst 0x00100073:
  - out_valid held 1, out_inst stable;
  - no new request issued;
  - release -> next request at pc+4.
REQ-038 Redirect in WAIT to 0x8000_0100, response 0xDEADBEEF arriving 3 cycles later:
  - response discarded, no out_valid;
  - next request at 0x8000_0100.
REQ-039 Redirect in HOLD with out_ready=1 in the same cycle, target 0x8000_0040:
  - handshake completes;
  - next request at 0x8000_0040.
REQ-040 Redirect to 0x8000_0042, IFU_MISALIGN_CHECK_EN defined:
  - request at 0x8000_0040;
  - misalign_err is a one-cycle pulse.
  Same stimulus, macro undefined:
  - request at 0x8000_0042;
  - misalign_err stays 0.
REQ-041 Reset asserted while in WAIT, stale response arrives 1 cycle after reset falls:
  - response ignored;
  - request reissued at 0x8000_0000.
